// File: rtl/csr_access_unit_if.sv
// Request, CSR-file and response signals shared between the CSR access unit
// and its environment; the unit uses the slave view, the requester the master view.
interface csr_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_field;
  logic [4:0]  req_rd;

  logic [11:0] csr_read_addr;
  logic [31:0] csr_data_read;
  logic        csr_write_en;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data_write;

  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_field, req_rd,
    input  req_ready,
    input  csr_read_addr, csr_write_en, csr_write_addr, csr_data_write,
    output csr_data_read,
    input  resp_valid, resp_rd, resp_data, resp_illegal,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_field, req_rd,
    output req_ready,
    output csr_read_addr, csr_write_en, csr_write_addr, csr_data_write,
    input  csr_data_read,
    output resp_valid, resp_rd, resp_data, resp_illegal,
    input  resp_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// Executes one RISC-V CSR instruction at a time as a read-modify-write on the
// CSR file: IDLE -> READ -> WRITE -> RESP, with all outputs registered.
module csr_access_unit #(
  parameter int CSR_ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  csr_access_unit_if.slave    bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Address bits above the implemented CSR space; any set bit makes the request illegal.
  localparam logic [11:0] ADDR_HI_MASK = 12'hFFF << CSR_ADDR_LEN;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [4:0]  rs1_field_q, rs1_field_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] old_q, old_d;
  logic        illegal_q, illegal_d;

  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        write_en_q, write_en_d;
  logic [11:0] write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_illegal_q, resp_illegal_d;

  logic [31:0] operand;
  logic [31:0] new_value;
  logic        suppress;

  always_comb begin
    operand   = funct3_q[2] ? {27'b0, rs1_field_q} : rs1_data_q;
    case (funct3_q[1:0])
      2'b10:   new_value = bus.csr_data_read | operand;
      2'b11:   new_value = bus.csr_data_read & ~operand;
      default: new_value = operand;
    endcase
    suppress  = (funct3_q[1:0] != 2'b01) && (rs1_field_q == 5'd0);

    state_d        = state_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    rs1_data_d     = rs1_data_q;
    rs1_field_d    = rs1_field_q;
    rd_d           = rd_q;
    old_d          = old_q;
    illegal_d      = illegal_q;
    req_ready_d    = req_ready_q;
    busy_d         = busy_q;
    write_en_d     = write_en_q;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    resp_valid_d   = resp_valid_q;
    resp_rd_d      = resp_rd_q;
    resp_data_d    = resp_data_q;
    resp_illegal_d = resp_illegal_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          funct3_d    = bus.req_funct3;
          addr_d      = bus.req_csr_addr;
          rs1_data_d  = bus.req_rs1_data;
          rs1_field_d = bus.req_rs1_field;
          rd_d        = bus.req_rd;
          illegal_d   = (bus.req_funct3[1:0] == 2'b00) ||
                        ((bus.req_csr_addr & ADDR_HI_MASK) != 12'd0);
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        old_d        = bus.csr_data_read;
        write_en_d   = !illegal_q && !suppress;
        write_addr_d = addr_q;
        write_data_d = new_value;
        state_d      = WRITE;
      end
      WRITE: begin
        write_en_d     = 1'b0;
        resp_valid_d   = 1'b1;
        resp_rd_d      = rd_q;
        resp_data_d    = illegal_q ? 32'd0 : old_q;
        resp_illegal_d = illegal_q;
        state_d        = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      funct3_q       <= '0;
      addr_q         <= '0;
      rs1_data_q     <= '0;
      rs1_field_q    <= '0;
      rd_q           <= '0;
      old_q          <= '0;
      illegal_q      <= 1'b0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      write_en_q     <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      resp_valid_q   <= 1'b0;
      resp_rd_q      <= '0;
      resp_data_q    <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      rs1_data_q     <= rs1_data_d;
      rs1_field_q    <= rs1_field_d;
      rd_q           <= rd_d;
      old_q          <= old_d;
      illegal_q      <= illegal_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      write_en_q     <= write_en_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_rd_q      <= resp_rd_d;
      resp_data_q    <= resp_data_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

  // The CSR file commits on the edge that ends WRITE, so a reset raised during
  // WRITE must mask the strobe immediately to keep that write from landing.
  assign bus.csr_write_en   = write_en_q & ~rst;
  assign bus.csr_write_addr = write_addr_q;
  assign bus.csr_data_write = write_data_q;
  assign bus.csr_read_addr  = addr_q;
  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rd        = resp_rd_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_illegal   = resp_illegal_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a bench-owned CSR file plus a
// reference model of CSR instruction semantics checked against random traffic.
module tb_csr_access_unit;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  csr_access_unit_if bus();

  csr_access_unit #(.CSR_ADDR_LEN(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  // Bench-owned CSR file: combinational read, write on the rising edge.
  logic [31:0] mem [0:15];
  logic [31:0] ref_mem [0:15];
  int          write_count = 0;
  logic [11:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic        preload_en = 1'b0;
  logic [3:0]  preload_addr;
  logic [31:0] preload_data;

  assign bus.csr_data_read = mem[bus.csr_read_addr[3:0]];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus.csr_write_en) begin
      mem[bus.csr_write_addr[3:0]] <= bus.csr_data_write;
      write_count  <= write_count + 1;
      last_wr_addr <= bus.csr_write_addr;
      last_wr_data <= bus.csr_data_write;
    end else if (preload_en) begin
      mem[preload_addr] <= preload_data;
    end
  end

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    preload_en   = 1'b1;
    preload_addr = a;
    preload_data = d;
    @(negedge clk);
    preload_en   = 1'b0;
    ref_mem[a]   = d;
  endtask

  // Drives one request from IDLE and observes its response; called at a negedge.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] d,
                       input logic [4:0] fld, input logic [4:0] rd, input int hold,
                       output int lat, output logic [31:0] rdata, output logic [4:0] rrd,
                       output logic rill, output int nwr, output bit stable, output bit tmo);
    int a;
    int wr0;
    int n;
    tmo = 0; stable = 1; lat = -1; nwr = 0; rdata = '0; rrd = '0; rill = 1'b0;
    bus.req_funct3 = f3; bus.req_csr_addr = addr; bus.req_rs1_data = d;
    bus.req_rs1_field = fld; bus.req_rd = rd; bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.req_ready !== 1'b1) begin tmo = 1; bus.req_valid = 1'b0; return; end
    a = cycle; wr0 = write_count;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.resp_valid !== 1'b1) begin tmo = 1; return; end
    lat = cycle - a; rdata = bus.resp_data; rrd = bus.resp_rd; rill = bus.resp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== rdata || bus.resp_rd !== rrd ||
          bus.resp_illegal !== rill || bus.req_ready !== 1'b0 || busy !== 1'b1)
        stable = 0;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    nwr = write_count - wr0;
  endtask

  // Reference semantics of a CSR instruction against the model CSR space.
  function automatic bit model_illegal(input logic [2:0] f3, input logic [11:0] addr);
    return (f3 == 3'd0) || (f3 == 3'd4) || (addr > 12'd15);
  endfunction

  function automatic bit model_writes(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] fld);
    if (model_illegal(f3, addr)) return 0;
    return (f3 == 3'd1) || (f3 == 3'd5) || (fld != 5'd0);
  endfunction

  function automatic logic [31:0] model_new(input logic [2:0] f3, input logic [31:0] old,
                                            input logic [31:0] d, input logic [4:0] fld);
    logic [31:0] op;
    op = (f3 >= 3'd5) ? 32'(fld) : d;
    if (f3 == 3'd1 || f3 == 3'd5) return op;
    if (f3 == 3'd2 || f3 == 3'd6) return old | op;
    return old & ~op;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd1; bus.req_csr_addr = 12'd3;
    bus.req_rs1_data = 32'hFFFF_FFFF; bus.req_rs1_field = 5'd9; bus.req_rd = 5'd9;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_req_ready got %b want 1", bus.req_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    tests_run++; if (bus.csr_write_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_write_en got %b want 0", bus.csr_write_en); end
    tests_run++; if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
    tests_run++; if (bus.resp_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_resp_illegal got %b want 0", bus.resp_illegal); end
    tests_run++;
    if ({bus.csr_read_addr, bus.csr_write_addr, bus.csr_data_write, bus.resp_data, bus.resp_rd} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_addr_data got ra=%h wa=%h wd=%h rdata=%h rrd=%h want all 0",
               bus.csr_read_addr, bus.csr_write_addr, bus.csr_data_write, bus.resp_data, bus.resp_rd);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_rst_idle got ready=%b busy=%b want 1/0", bus.req_ready, busy); end
  endtask

  task automatic test_spec_vectors();
    int lat; logic [31:0] rdata; logic [4:0] rrd; logic rill; int nwr; bit stable; bit tmo;
    preload(4'd3, 32'h0000_00F0);
    issue(3'b010, 12'h003, 32'h0F, 5'd1, 5'd7, 0, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo) begin tests_failed++; $display("[TB] FAIL rs_timeout got timeout want response"); end
    tests_run++; if (lat != 3) begin tests_failed++; $display("[TB] FAIL rs_latency got %0d want 3", lat); end
    tests_run++; if (rdata !== 32'hF0 || rrd !== 5'd7 || rill !== 1'b0) begin tests_failed++; $display("[TB] FAIL rs_resp got data=%h rd=%0d ill=%b want f0/7/0", rdata, rrd, rill); end
    tests_run++; if (nwr != 1 || last_wr_addr !== 12'h003 || last_wr_data !== 32'hFF) begin tests_failed++; $display("[TB] FAIL rs_write got n=%0d a=%h d=%h want 1/003/ff", nwr, last_wr_addr, last_wr_data); end

    preload(4'd5, 32'hFF);
    issue(3'b111, 12'h005, 32'h0, 5'h0F, 5'd3, 0, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo || rdata !== 32'hFF || nwr != 1 || last_wr_data !== 32'hF0) begin tests_failed++; $display("[TB] FAIL rci got tmo=%0b data=%h n=%0d wd=%h want 0/ff/1/f0", tmo, rdata, nwr, last_wr_data); end
    issue(3'b110, 12'h005, 32'hFFFF_FFFF, 5'd0, 5'd3, 0, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo || rdata !== 32'hF0 || nwr != 0) begin tests_failed++; $display("[TB] FAIL rsi_zero got tmo=%0b data=%h n=%0d want 0/f0/0", tmo, rdata, nwr); end

    issue(3'b001, 12'h010, 32'h1234, 5'd4, 5'd8, 0, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo || rill !== 1'b1 || rdata !== 32'd0 || nwr != 0) begin tests_failed++; $display("[TB] FAIL ill_addr got tmo=%0b ill=%b data=%h n=%0d want 0/1/0/0", tmo, rill, rdata, nwr); end
    issue(3'b100, 12'h002, 32'h1234, 5'd4, 5'd8, 0, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo || rill !== 1'b1 || rdata !== 32'd0 || nwr != 0) begin tests_failed++; $display("[TB] FAIL ill_funct3 got tmo=%0b ill=%b data=%h n=%0d want 0/1/0/0", tmo, rill, rdata, nwr); end

    preload(4'd2, 32'h0000_0042);
    issue(3'b001, 12'h002, 32'hDEAD_BEEF, 5'd6, 5'd0, 5, lat, rdata, rrd, rill, nwr, stable, tmo);
    tests_run++; if (tmo || nwr != 1 || last_wr_data !== 32'hDEAD_BEEF || rdata !== 32'h42 || rrd !== 5'd0) begin tests_failed++; $display("[TB] FAIL rw_rd0 got tmo=%0b n=%0d wd=%h data=%h rd=%0d want 0/1/deadbeef/42/0", tmo, nwr, last_wr_data, rdata, rrd); end
    tests_run++; if (!stable) begin tests_failed++; $display("[TB] FAIL hold_stable got unstable want stable"); end
    tests_run++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL after_resp_idle got ready=%b busy=%b want 1/0", bus.req_ready, busy); end
  endtask

  task automatic test_back_to_back();
    int a1; int a2; int n; logic [31:0] resp_q[$];
    preload(4'd4, 32'h55);
    bus.resp_ready = 1'b1;
    bus.req_funct3 = 3'b001; bus.req_csr_addr = 12'h004; bus.req_rs1_data = 32'h11;
    bus.req_rs1_field = 5'd2; bus.req_rd = 5'd1; bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    a1 = cycle;
    @(negedge clk);
    bus.req_funct3 = 3'b010; bus.req_rs1_data = 32'h22; bus.req_rs1_field = 5'd5; bus.req_rd = 5'd2;
    n = 0;
    while (n < 20) begin
      if (bus.resp_valid === 1'b1) resp_q.push_back(bus.resp_data);
      if (bus.req_ready === 1'b1) break;
      @(negedge clk); n++;
    end
    a2 = cycle;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.resp_valid === 1'b1) resp_q.push_back(bus.resp_data);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    tests_run++; if (a2 - a1 < 4) begin tests_failed++; $display("[TB] FAIL b2b_spacing got %0d want >=4", a2 - a1); end
    tests_run++;
    if (resp_q.size() != 2) begin tests_failed++; $display("[TB] FAIL b2b_resp_count got %0d want 2", resp_q.size()); end
    else if (resp_q[0] !== 32'h55 || resp_q[1] !== 32'h11) begin tests_failed++; $display("[TB] FAIL b2b_resp_data got %h,%h want 55,11", resp_q[0], resp_q[1]); end
    tests_run++; if (mem[4] !== 32'h33) begin tests_failed++; $display("[TB] FAIL b2b_final got %h want 33", mem[4]); end
    ref_mem[4] = 32'h33;
  endtask

  task automatic test_reset_mid_write();
    int n; int wr0;
    preload(4'd1, 32'h0000_1234);
    bus.req_funct3 = 3'b001; bus.req_csr_addr = 12'h001; bus.req_rs1_data = 32'hAAAA_5555;
    bus.req_rs1_field = 5'd3; bus.req_rd = 5'd2; bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    wr0 = write_count;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.csr_write_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_write_en got %b want 1", bus.csr_write_en); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.csr_write_en !== 1'b0 || bus.resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_outputs got we=%b rv=%b want 0/0", bus.csr_write_en, bus.resp_valid); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_idle got ready=%b busy=%b rv=%b want 1/0/0", bus.req_ready, busy, bus.resp_valid); end
    tests_run++; if (mem[1] !== 32'h1234 || write_count != wr0) begin tests_failed++; $display("[TB] FAIL abort_csr got %h writes=%0d want 1234 writes=0", mem[1], write_count - wr0); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rdata; logic [4:0] rrd; logic rill; int nwr; bit stable; bit tmo;
    logic [2:0] f3; logic [11:0] addr; logic [31:0] d; logic [4:0] fld; logic [4:0] rd; int hold;
    logic [31:0] old_exp;
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
    for (int t = 0; t < 40; t++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
      d    = $urandom;
      fld  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = 5'($urandom_range(0, 31));
      hold = $urandom_range(0, 2);
      issue(f3, addr, d, fld, rd, hold, lat, rdata, rrd, rill, nwr, stable, tmo);
      old_exp = model_illegal(f3, addr) ? 32'd0 : ref_mem[addr[3:0]];
      tests_run++;
      if (tmo || lat != 3 || !stable) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_timing got tmo=%0b lat=%0d stable=%0b want 0/3/1", t, tmo, lat, stable);
      end
      tests_run++;
      if (rdata !== old_exp || rrd !== rd || rill !== model_illegal(f3, addr)) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_resp f3=%0d a=%h got %h/%0d/%b want %h/%0d/%b",
                                 t, f3, addr, rdata, rrd, rill, old_exp, rd, model_illegal(f3, addr));
      end
      tests_run++;
      if (model_writes(f3, addr, fld)) begin
        ref_mem[addr[3:0]] = model_new(f3, old_exp, d, fld);
        if (nwr != 1 || last_wr_addr !== addr || last_wr_data !== ref_mem[addr[3:0]]) begin
          tests_failed++; $display("[TB] FAIL rnd%0d_write got n=%0d a=%h d=%h want 1/%h/%h",
                                   t, nwr, last_wr_addr, last_wr_data, addr, ref_mem[addr[3:0]]);
        end
      end else if (nwr != 0) begin
        tests_failed++; $display("[TB] FAIL rnd%0d_nowrite got %0d writes want 0", t, nwr);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (mem[i] !== ref_mem[i]) begin tests_failed++; $display("[TB] FAIL final_csr%0d got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.req_funct3 = '0; bus.req_csr_addr = '0; bus.req_rs1_data = '0;
    bus.req_rs1_field = '0; bus.req_rd = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
